ym2149_bus_master: RTL and testbench
====================================

// Module: ym2149_bus_master
// PURPOSE
//  Bus initiator for the YM2149 PSG: turns queued register write/read requests into the
//  BDIR/BC address-latch, write and read phase sequence the PSG expects. Sits between the
//  Mockingboard VIA/CPU-side logic and the PSG's BDIR/BC/DI/DO pins.
//  Read data captured from the PSG is returned on a one-cycle response strobe.
// PARAMETERS
//  HOLD_CYCLES  1  CE ticks each ADDR/WRITE/READ phase is held; legal range 1..15
//  FIFO_DEPTH   4  request queue entries; power of two, 2..16
// PORTS
//  CLK        in   1  global clock
//  RESET_N    in   1  asynchronous, active-low reset
//  CE         in   1  PSG clock enable; the FSM and phase counter advance only when CE=1
//  REQ_VALID  in   1  request present
//  REQ_READY  out  1  queue not full; transfer on REQ_VALID & REQ_READY at posedge CLK
//  REQ_WR     in   1  1 = register write, 0 = register read
//  REQ_ADDR   in   4  PSG register number 0..15
//  REQ_DATA   in   8  write data; ignored for reads
//  RSP_VALID  out  1  one-CLK pulse: read data valid
//  RSP_DATA   out  8  captured read data; holds until the next read completes
//  BUSY       out  1  queue non-empty or FSM not IDLE
//  PSG_BDIR   out  1  to PSG BDIR
//  PSG_BC     out  1  to PSG BC
//  PSG_DO     out  8  to PSG DI
//  PSG_DI     in   8  from PSG DO
// BEHAVIOUR
//  Reset (async, RESET_N=0): queue emptied; FSM=IDLE; PSG_BDIR=0, PSG_BC=0, PSG_DO=0;
//   RSP_VALID=0, RSP_DATA=0, BUSY=0, REQ_READY=1 once RESET_N deasserts.
//   Reset mid-transaction aborts it; the bus returns to inactive (0,0) immediately.
//  Queue: FIFO of {wr,addr,data}. REQ_READY = !full, independent of pop that cycle
//   (no push when full, even if a pop occurs). Push and pop in the same cycle are legal.
//  FSM, registered outputs (BDIR,BC / PSG_DO):
//   IDLE  (0,0)/hold: on CE and queue non-empty -> pop, go to ADDR
//   ADDR  (1,1)/{4'h0,addr}: HOLD_CYCLES CE ticks -> GAP1
//   GAP1  (0,0)/hold: 1 CE tick -> WRITE if wr, else READ
//   WRITE (1,0)/data: HOLD_CYCLES CE ticks -> GAP2
//   READ  (0,1)/hold: HOLD_CYCLES CE ticks; on final tick PSG_DI -> RSP_DATA, RSP_VALID=1
//   GAP2  (0,0)/hold: 1 CE tick -> IDLE
//  BDIR=BC=1 and BDIR=1,BC=0 never appear back to back; GAP1 always separates them.
//  Phase counter: 4 bits, loaded with HOLD_CYCLES-1 on phase entry, decrements on CE;
//   phase ends on the CE tick with counter=0. No wrap.
//  Outputs change only on CLK edges following a CE=1 cycle; with CE=0 every output holds.
//  Latency (CE=1 every CLK, HOLD_CYCLES=1, empty queue): request accepted at edge 0;
//   ADDR visible after edge 1; GAP1 edge 2; WRITE/READ edge 3; GAP2 edge 4; IDLE edge 5.
//   Read: RSP_VALID high for the CLK after edge 4. Transaction = 2*HOLD_CYCLES+3 CE ticks.
//  IDLE with queue empty: no pop; BUSY=0. Next queued entry starts from IDLE without skipping it.
//  RSP_VALID has no backpressure; the consumer must accept it in that cycle.
// TESTING
//  Write reg7=0x38, HOLD=1, CE=1 -> PSG pins (1,1,0x07),(0,0),(1,0,0x38),(0,0),(0,0); BUSY 0 after.
//  PSG_DI=0xA5, read reg14 -> (1,1,0x0E),(0,0),(0,1),(0,0); RSP_VALID one CLK, RSP_DATA=0xA5.
//  Push 5 back-to-back writes, FIFO_DEPTH=4 -> REQ_READY low on 5th until first pop; all 5 in order.
//  CE every 4th CLK, HOLD=2 -> each ADDR/WRITE phase lasts 8 CLKs; outputs frozen between CEs.
//  RESET_N low during WRITE phase -> BDIR/BC=0 same cycle; queue empty; next request runs clean.
//  With a real YM2149 instance: write reg13=0x0E then read reg13 -> RSP_DATA=0x0E.

Source files
------------

// File: rtl/ym2149_bus_master.sv
// YM2149 PSG bus initiator: queued register writes/reads
// driven as BDIR/BC address, write and read phases.
module ym2149_bus_master #(
    parameter int HOLD_CYCLES = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CE,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic       REQ_WR,
    input  logic [3:0] REQ_ADDR,
    input  logic [7:0] REQ_DATA,
    output logic       RSP_VALID,
    output logic [7:0] RSP_DATA,
    output logic       BUSY,
    output logic       PSG_BDIR,
    output logic       PSG_BC,
    output logic [7:0] PSG_DO,
    input  logic [7:0] PSG_DI
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_GAP1,
        S_WRITE,
        S_READ,
        S_GAP2
    } state_t;

    logic [12:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [12:0]   head;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic       cur_wr, cur_wr_n;
    logic [7:0] cur_data, cur_data_n;
    logic       bdir, bdir_n;
    logic       bc, bc_n;
    logic [7:0] do_q, do_n;
    logic       rsp_valid, rsp_valid_n;
    logic [7:0] rsp_data, rsp_data_n;
    logic       last;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = REQ_VALID && !full;
    assign pop   = CE && (state == S_IDLE) && !empty;
    assign head  = mem[rptr];
    assign last  = (cnt == 4'd0);

    assign REQ_READY = !full;
    assign BUSY      = !empty || (state != S_IDLE);
    assign PSG_BDIR  = bdir;
    assign PSG_BC    = bc;
    assign PSG_DO    = do_q;
    assign RSP_VALID = rsp_valid;
    assign RSP_DATA  = rsp_data;

    // Queue storage; contents need no reset, pointers guard them.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wptr] <= {REQ_WR, REQ_ADDR, REQ_DATA};
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FSM, phase counter and registered bus outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= S_IDLE;
            cnt       <= '0;
            cur_wr    <= 1'b0;
            cur_data  <= '0;
            bdir      <= 1'b0;
            bc        <= 1'b0;
            do_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cur_wr    <= cur_wr_n;
            cur_data  <= cur_data_n;
            bdir      <= bdir_n;
            bc        <= bc_n;
            do_q      <= do_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
        end
    end

    // Next-state and next-output decode; nothing moves without CE.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        cur_wr_n    = cur_wr;
        cur_data_n  = cur_data;
        bdir_n      = bdir;
        bc_n        = bc;
        do_n        = do_q;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        if (CE) begin
            unique case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state_n    = S_ADDR;
                        cnt_n      = HOLD_M1;
                        cur_wr_n   = head[12];
                        cur_data_n = head[7:0];
                        bdir_n     = 1'b1;
                        bc_n       = 1'b1;
                        do_n       = {4'h0, head[11:8]};
                    end
                end
                S_ADDR: begin
                    if (last) begin
                        state_n = S_GAP1;
                        bdir_n  = 1'b0;
                        bc_n    = 1'b0;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                S_GAP1: begin
                    cnt_n = HOLD_M1;
                    if (cur_wr) begin
                        state_n = S_WRITE;
                        bdir_n  = 1'b1;
                        bc_n    = 1'b0;
                        do_n    = cur_data;
                    end else begin
                        state_n = S_READ;
                        bdir_n  = 1'b0;
                        bc_n    = 1'b1;
                    end
                end
                S_WRITE: begin
                    if (last) begin
                        state_n = S_GAP2;
                        bdir_n  = 1'b0;
                        bc_n    = 1'b0;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                S_READ: begin
                    if (last) begin
                        state_n     = S_GAP2;
                        bdir_n      = 1'b0;
                        bc_n        = 1'b0;
                        rsp_valid_n = 1'b1;
                        rsp_data_n  = PSG_DI;
                    end else begin
                        cnt_n = cnt - 4'd1;
                    end
                end
                S_GAP2: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                    bdir_n  = 1'b0;
                    bc_n    = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ym2149_bus_master.sv
// Directed bench for ym2149_bus_master: pin sequences,
// queue backpressure, slow CE, mid-transfer reset, PSG model.
module tb_ym2149_bus_master;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ce = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_wr = 1'b0;
    logic [3:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic       bdir;
    logic       bc;
    logic [7:0] psg_do;
    logic [7:0] psg_di;
    logic [7:0] psg_drv = '0;
    logic       use_model = 1'b0;

    logic       ce2 = 1'b0;
    logic       req_valid2 = 1'b0;
    logic       req_ready2;
    logic       rsp_valid2;
    logic [7:0] rsp_data2;
    logic       busy2;
    logic       bdir2;
    logic       bc2;
    logic [7:0] psg_do2;

    logic [7:0] regs [16];
    logic [3:0] lat = '0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ym2149_bus_master #(.HOLD_CYCLES(1), .FIFO_DEPTH(4)) dut (
        .CLK(clk), .RESET_N(rst_n), .CE(ce),
        .REQ_VALID(req_valid), .REQ_READY(req_ready),
        .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data), .BUSY(busy),
        .PSG_BDIR(bdir), .PSG_BC(bc), .PSG_DO(psg_do), .PSG_DI(psg_di)
    );

    ym2149_bus_master #(.HOLD_CYCLES(2), .FIFO_DEPTH(4)) dut2 (
        .CLK(clk), .RESET_N(rst_n), .CE(ce2),
        .REQ_VALID(req_valid2), .REQ_READY(req_ready2),
        .REQ_WR(req_wr), .REQ_ADDR(req_addr), .REQ_DATA(req_data),
        .RSP_VALID(rsp_valid2), .RSP_DATA(rsp_data2), .BUSY(busy2),
        .PSG_BDIR(bdir2), .PSG_BC(bc2), .PSG_DO(psg_do2), .PSG_DI(psg_di)
    );

    // Tiny PSG register file: latch address, then write or read it.
    always @(posedge clk) begin
        if (bdir && bc) lat <= psg_do[3:0];
        else if (bdir && !bc) regs[lat] <= psg_do;
    end
    assign psg_di = use_model ? regs[lat] : psg_drv;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #20;
        total++;
        if ({bdir, bc} !== 2'b00) begin
            bad++; $display("FAIL reset_bus got=%b want=00", {bdir, bc});
        end
        total++;
        if (psg_do !== 8'h00) begin
            bad++; $display("FAIL reset_do got=%h want=00", psg_do);
        end
        total++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            bad++; $display("FAIL reset_rsp got=%b/%h want=0/00", rsp_valid, rsp_data);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (req_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic run_write(input logic [3:0] a, input logic [7:0] d);
        logic [9:0] exp_v [5];
        logic [9:0] got;
        exp_v[0] = {2'b11, 4'h0, a};
        exp_v[1] = {2'b00, 4'h0, a};
        exp_v[2] = {2'b10, d};
        exp_v[3] = {2'b00, d};
        exp_v[4] = {2'b00, d};
        ce = 1'b1;
        req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_data = d;
        tick();
        req_valid = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL wr_busy_start got=%b want=1", busy);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            got = {bdir, bc, psg_do};
            total++;
            if (got !== exp_v[i]) begin
                bad++;
                $display("FAIL wr_step%0d reg%0d got=%b/%h want=%b/%h",
                         i, a, got[9:8], got[7:0], exp_v[i][9:8], exp_v[i][7:0]);
            end
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL wr_busy_end got=%b want=0", busy);
        end
    endtask

    task automatic test_write;
        run_write(4'd7, 8'h38);
    endtask

    task automatic test_read;
        logic [10:0] exp_v [5];
        logic [10:0] got;
        exp_v[0] = {2'b11, 8'h0E, 1'b0};
        exp_v[1] = {2'b00, 8'h0E, 1'b0};
        exp_v[2] = {2'b01, 8'h0E, 1'b0};
        exp_v[3] = {2'b00, 8'h0E, 1'b1};
        exp_v[4] = {2'b00, 8'h0E, 1'b0};
        use_model = 1'b0;
        psg_drv = 8'hA5;
        ce = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd14; req_data = 8'hFF;
        tick();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            got = {bdir, bc, psg_do, rsp_valid};
            total++;
            if (got !== exp_v[i]) begin
                bad++;
                $display("FAIL rd_step%0d got=%b/%h/%b want=%b/%h/%b", i,
                         got[10:9], got[8:1], got[0],
                         exp_v[i][10:9], exp_v[i][8:1], exp_v[i][0]);
            end
        end
        total++;
        if (rsp_data !== 8'hA5) begin
            bad++; $display("FAIL rd_data got=%h want=a5", rsp_data);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rd_busy_end got=%b want=0", busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [11:0] seen [$];
        logic [3:0]  cur_a;
        logic        prev11;
        int          adj_bad;
        int          n;
        cur_a = '0; prev11 = 1'b0; adj_bad = 0; n = 0;
        ce = 1'b0;
        req_wr = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr = 4'(i + 1);
            req_data = 8'(8'h11 * (i + 1));
            total++;
            if (req_ready !== 1'b1) begin
                bad++; $display("FAIL b2b_ready%0d got=%b want=1", i, req_ready);
            end
            tick();
        end
        req_addr = 4'd5; req_data = 8'h55;
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_full got=%b want=0", req_ready);
        end
        tick();
        total++;
        if (req_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_full_hold got=%b want=0", req_ready);
        end
        ce = 1'b1;
        while (n < 80) begin
            tick();
            if (n == 0) begin
                total++;
                if (req_ready !== 1'b1) begin
                    bad++; $display("FAIL b2b_ready_after_pop got=%b want=1", req_ready);
                end
            end
            if (n == 1) req_valid = 1'b0;
            if (bdir && bc) cur_a = psg_do[3:0];
            if (bdir && !bc) begin
                seen.push_back({cur_a, psg_do});
                if (prev11) adj_bad++;
            end
            prev11 = bdir && bc;
            n++;
            if (n > 2 && !busy) break;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL b2b_timeout busy=%b want=0", busy);
        end
        total++;
        if (seen.size() != 5) begin
            bad++; $display("FAIL b2b_count got=%0d want=5", seen.size());
        end
        for (int i = 0; i < seen.size() && i < 5; i++) begin
            total++;
            if (seen[i] !== {4'(i + 1), 8'(8'h11 * (i + 1))}) begin
                bad++;
                $display("FAIL b2b_order%0d got=%h want=%h", i, seen[i],
                         {4'(i + 1), 8'(8'h11 * (i + 1))});
            end
        end
        total++;
        if (adj_bad != 0) begin
            bad++; $display("FAIL b2b_adjacent got=%0d want=0", adj_bad);
        end
    endtask

    task automatic test_ce_slow;
        logic [9:0] prev;
        logic       ce_was;
        int         n11, n10, frozen_bad;
        logic [7:0] wdata;
        n11 = 0; n10 = 0; frozen_bad = 0; wdata = '0;
        ce2 = 1'b0;
        req_valid2 = 1'b1; req_wr = 1'b1; req_addr = 4'd3; req_data = 8'h5A;
        tick();
        req_valid2 = 1'b0;
        for (int c = 0; c < 60; c++) begin
            ce2 = (c % 4 == 3);
            ce_was = ce2;
            prev = {bdir2, bc2, psg_do2};
            tick();
            if (!ce_was && ({bdir2, bc2, psg_do2} !== prev)) frozen_bad++;
            if (bdir2 && bc2) n11++;
            if (bdir2 && !bc2) begin
                n10++;
                wdata = psg_do2;
            end
        end
        ce2 = 1'b0;
        total++;
        if (n11 != 8) begin
            bad++; $display("FAIL slow_addr_len got=%0d want=8", n11);
        end
        total++;
        if (n10 != 8) begin
            bad++; $display("FAIL slow_write_len got=%0d want=8", n10);
        end
        total++;
        if (wdata !== 8'h5A) begin
            bad++; $display("FAIL slow_wdata got=%h want=5a", wdata);
        end
        total++;
        if (frozen_bad != 0) begin
            bad++; $display("FAIL slow_frozen got=%0d want=0", frozen_bad);
        end
        total++;
        if (busy2 !== 1'b0) begin
            bad++; $display("FAIL slow_busy got=%b want=0", busy2);
        end
    endtask

    task automatic test_reset_mid;
        ce = 1'b1;
        req_wr = 1'b1;
        req_valid = 1'b1; req_addr = 4'd9; req_data = 8'h77;
        tick();
        req_addr = 4'd10; req_data = 8'h66;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        total++;
        if ({bdir, bc, psg_do} !== {2'b10, 8'h77}) begin
            bad++; $display("FAIL rst_mid_phase got=%b/%h want=10/77", {bdir, bc}, psg_do);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bdir, bc} !== 2'b00 || psg_do !== 8'h00) begin
            bad++; $display("FAIL rst_mid_bus got=%b/%h want=00/00", {bdir, bc}, psg_do);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_busy got=%b want=0", busy);
        end
        #2 rst_n = 1'b1;
        tick();
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL rst_mid_empty got=%b want=0", busy);
        end
        run_write(4'd2, 8'h44);
    endtask

    task automatic test_psg_model;
        int n;
        use_model = 1'b1;
        run_write(4'd13, 8'h0E);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 4'd13; req_data = 8'h00;
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (rsp_valid !== 1'b1) begin
            bad++; $display("FAIL model_timeout rsp_valid=%b want=1", rsp_valid);
        end
        total++;
        if (rsp_data !== 8'h0E) begin
            bad++; $display("FAIL model_data got=%h want=0e", rsp_data);
        end
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_ce_slow();
        test_reset_mid();
        test_psg_model();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
